// File: rtl/bus_driver_decoder_pkg.sv
// Shared CPU bus definitions: bus source codes, decoder limits and the driver FSM encoding.
// Imported by the one-hot decoder and by the bus driver decoder top level.
package bus_driver_decoder_pkg;

  localparam int CODE_W = 5;
  localparam int DRV_W  = 32;

  localparam int NUM_SOURCES_DEFAULT = 24;
  localparam int GAP_CYCLES_DEFAULT  = 1;

  localparam logic [CODE_W-1:0] SRC_R0     = 5'd0;
  localparam logic [CODE_W-1:0] SRC_R1     = 5'd1;
  localparam logic [CODE_W-1:0] SRC_R2     = 5'd2;
  localparam logic [CODE_W-1:0] SRC_R3     = 5'd3;
  localparam logic [CODE_W-1:0] SRC_R4     = 5'd4;
  localparam logic [CODE_W-1:0] SRC_R5     = 5'd5;
  localparam logic [CODE_W-1:0] SRC_R6     = 5'd6;
  localparam logic [CODE_W-1:0] SRC_R7     = 5'd7;
  localparam logic [CODE_W-1:0] SRC_R8     = 5'd8;
  localparam logic [CODE_W-1:0] SRC_R9     = 5'd9;
  localparam logic [CODE_W-1:0] SRC_R10    = 5'd10;
  localparam logic [CODE_W-1:0] SRC_R11    = 5'd11;
  localparam logic [CODE_W-1:0] SRC_R12    = 5'd12;
  localparam logic [CODE_W-1:0] SRC_R13    = 5'd13;
  localparam logic [CODE_W-1:0] SRC_R14    = 5'd14;
  localparam logic [CODE_W-1:0] SRC_R15    = 5'd15;
  localparam logic [CODE_W-1:0] SRC_HI     = 5'd16;
  localparam logic [CODE_W-1:0] SRC_LO     = 5'd17;
  localparam logic [CODE_W-1:0] SRC_ZHI    = 5'd18;
  localparam logic [CODE_W-1:0] SRC_ZLO    = 5'd19;
  localparam logic [CODE_W-1:0] SRC_PC     = 5'd20;
  localparam logic [CODE_W-1:0] SRC_MDR    = 5'd21;
  localparam logic [CODE_W-1:0] SRC_INPORT = 5'd22;
  localparam logic [CODE_W-1:0] SRC_CSIGN  = 5'd23;
  localparam logic [CODE_W-1:0] SRC_NONE   = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } bus_state_e;

  // A code names a real driver only below the configured source count.
  function automatic logic code_is_legal(input logic [CODE_W-1:0] code,
                                         input logic [CODE_W:0]   limit);
    return ({1'b0, code} < limit);
  endfunction

endpackage

// File: rtl/bus_driver_decoder_onehot_dec.sv
// Combinational 5-to-32 one-hot decoder; codes at or above NUM_SOURCES decode to all zero
// so an illegal code can never enable a driver.
module onehot_dec_5_to_32
  import bus_driver_decoder_pkg::*;
#(
  parameter int NUM_SOURCES = NUM_SOURCES_DEFAULT
) (
  input  logic [CODE_W-1:0] code,
  output logic [DRV_W-1:0]  onehot
);

  localparam logic [CODE_W:0] LIMIT = (CODE_W+1)'(NUM_SOURCES);

  // Decode with gating for codes outside the legal source range.
  always_comb begin
    onehot = 32'd0;
    if (code_is_legal(code, LIMIT)) begin
      onehot[code] = 1'b1;
    end else begin
      onehot = 32'd0;
    end
  end

endmodule

// File: rtl/bus_driver_decoder.sv
// Bus source decoder: turns requested source codes into registered one-hot driver enables,
// inserting an all-off gap between two different drivers so they never overlap on the bus.
module bus_driver_decoder
  import bus_driver_decoder_pkg::*;
#(
  parameter int NUM_SOURCES = NUM_SOURCES_DEFAULT,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEFAULT,
  parameter int NONE_CODE   = 31
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_code,
  output logic              req_ready,
  output logic [DRV_W-1:0]  drv_en,
  output logic [CODE_W-1:0] drv_code,
  output logic              busy,
  output logic              err_illegal
);

  localparam logic [CODE_W-1:0] NONE     = CODE_W'(NONE_CODE);
  localparam logic [CODE_W:0]   LIMIT    = (CODE_W+1)'(NUM_SOURCES);
  localparam logic [2:0]        GAP_LOAD = 3'(GAP_CYCLES - 1);

  bus_state_e        state_r, state_s;
  logic [2:0]        gap_cnt_r, gap_cnt_s;
  logic [CODE_W-1:0] pend_r, pend_s;
  logic [DRV_W-1:0]  drv_en_r, drv_en_s;
  logic [CODE_W-1:0] drv_code_r, drv_code_s;
  logic              busy_r, busy_s;
  logic              err_r, err_s;

  logic              accept_s;
  logic              legal_s;
  logic              is_none_s;
  logic [CODE_W-1:0] dec_code_s;
  logic [DRV_W-1:0]  dec_en_s;

  assign accept_s   = req_valid & (state_r != ST_GAP);
  assign legal_s    = code_is_legal(req_code, LIMIT);
  assign is_none_s  = (req_code == NONE);
  // During the gap the decoder looks at the parked code, otherwise at the live request.
  assign dec_code_s = (state_r == ST_GAP) ? pend_r : req_code;

  onehot_dec_5_to_32 #(
    .NUM_SOURCES (NUM_SOURCES)
  ) u_dec (
    .code   (dec_code_s),
    .onehot (dec_en_s)
  );

  // Next-state and next-output computation for the driver FSM.
  always_comb begin
    state_s    = state_r;
    gap_cnt_s  = gap_cnt_r;
    pend_s     = pend_r;
    drv_en_s   = drv_en_r;
    drv_code_s = drv_code_r;
    err_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DRIVE: begin
        if (accept_s) begin
          if (legal_s) begin
            if ((state_r == ST_IDLE) || (req_code == drv_code_r)) begin
              drv_en_s   = dec_en_s;
              drv_code_s = req_code;
              state_s    = ST_DRIVE;
            end else begin
              drv_en_s   = 32'd0;
              drv_code_s = NONE;
              pend_s     = req_code;
              gap_cnt_s  = GAP_LOAD;
              state_s    = ST_GAP;
            end
          end else begin
            // Release and illegal codes both leave the bus undriven; only illegal ones flag.
            drv_en_s   = 32'd0;
            drv_code_s = NONE;
            pend_s     = NONE;
            state_s    = ST_IDLE;
            err_s      = ~is_none_s;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 3'd0) begin
          drv_en_s   = dec_en_s;
          drv_code_s = pend_r;
          pend_s     = NONE;
          state_s    = ST_DRIVE;
        end else begin
          gap_cnt_s = gap_cnt_r - 3'd1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        gap_cnt_s  = 3'd0;
        pend_s     = NONE;
        drv_en_s   = 32'd0;
        drv_code_s = NONE;
      end
    endcase
    busy_s = (state_s == ST_GAP);
  end

  // State, counter, pending code and output registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r    <= ST_IDLE;
      gap_cnt_r  <= 3'd0;
      pend_r     <= NONE;
      drv_en_r   <= 32'd0;
      drv_code_r <= NONE;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      gap_cnt_r  <= gap_cnt_s;
      pend_r     <= pend_s;
      drv_en_r   <= drv_en_s;
      drv_code_r <= drv_code_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
    end
  end

  assign req_ready   = (state_r != ST_GAP);
  assign drv_en      = drv_en_r;
  assign drv_code    = drv_code_r;
  assign busy        = busy_r;
  assign err_illegal = err_r;

endmodule

// File: tb/tb_bus_driver_decoder.sv
// Scoreboard bench for bus_driver_decoder: two instances (gap 1 and gap 3) share one
// request stream; an abstract driver model predicts each cycle, a monitor compares.
module tb_bus_driver_decoder;

  typedef struct {
    int cur;
    int pend;
    int gap_left;
    bit err;
  } mstate_t;

  typedef struct {
    logic [31:0] en;
    logic [4:0]  code;
    bit          busy;
    bit          ready;
    bit          err;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        req_valid = 1'b0;
  logic [4:0]  req_code = 5'd31;

  logic        ready_a, busy_a, err_a;
  logic [31:0] en_a;
  logic [4:0]  code_a;
  logic        ready_b, busy_b, err_b;
  logic [31:0] en_b;
  logic [4:0]  code_b;

  int checks = 0;
  int failures = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  mstate_t     ms_a, ms_b;
  logic [31:0] prev_en [2];

  bus_driver_decoder #(.NUM_SOURCES(24), .GAP_CYCLES(1), .NONE_CODE(31)) dut_a (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_code(req_code),
    .req_ready(ready_a), .drv_en(en_a), .drv_code(code_a), .busy(busy_a), .err_illegal(err_a));

  bus_driver_decoder #(.NUM_SOURCES(24), .GAP_CYCLES(3), .NONE_CODE(31)) dut_b (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_code(req_code),
    .req_ready(ready_b), .drv_en(en_b), .drv_code(code_b), .busy(busy_b), .err_illegal(err_b));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic mstate_t model_reset();
    mstate_t s;
    s.cur = -1; s.pend = 31; s.gap_left = 0; s.err = 1'b0;
    return s;
  endfunction

  // Abstract rules: a driver change costs `g` undriven cycles; release/illegal drop the bus.
  function automatic mstate_t model_next(mstate_t s, int g, bit v, int c);
    mstate_t n = s;
    n.err = 1'b0;
    if (s.gap_left > 0) begin
      n.gap_left = s.gap_left - 1;
      if (n.gap_left == 0) n.cur = s.pend;
    end else if (v) begin
      if (c == 31) n.cur = -1;
      else if (c >= 24) begin n.cur = -1; n.err = 1'b1; end
      else if (s.cur < 0 || s.cur == c) n.cur = c;
      else begin n.cur = -1; n.pend = c; n.gap_left = g; end
    end
    return n;
  endfunction

  function automatic exp_t mk_exp(mstate_t s);
    exp_t e;
    e.en    = (s.cur < 0) ? 32'd0 : (32'd1 << s.cur);
    e.code  = (s.cur < 0) ? 5'd31 : 5'(s.cur);
    e.busy  = (s.gap_left > 0);
    e.ready = !(s.gap_left > 0);
    e.err   = s.err;
    return e;
  endfunction

  // Bus encoder reference: index of the single set bit, 31 when none is set.
  function automatic logic [4:0] bus_encode(logic [31:0] en);
    logic [4:0] r = 5'd31;
    for (int i = 31; i >= 0; i--) if (en[i]) r = 5'(i);
    return r;
  endfunction

  task automatic check_dut(input int k, input exp_t e, input logic [31:0] en, input logic [4:0] code,
                           input logic busy, input logic ready, input logic err);
    string p = (k == 0) ? "g1" : "g3";
    chk({p, "_drv_en"}, en, e.en);
    chk({p, "_drv_code"}, {27'd0, code}, {27'd0, e.code});
    chk({p, "_busy"}, {31'd0, busy}, {31'd0, e.busy});
    chk({p, "_req_ready"}, {31'd0, ready}, {31'd0, e.ready});
    chk({p, "_err_illegal"}, {31'd0, err}, {31'd0, e.err});
    chk({p, "_encode_matches"}, {27'd0, bus_encode(en)}, {27'd0, code});
    chk({p, "_onehot"}, {31'd0, ($countones(en) > 1)}, 32'd0);
    chk({p, "_no_direct_switch"},
        {31'd0, (prev_en[k] != 32'd0 && en != 32'd0 && prev_en[k] != en)}, 32'd0);
    prev_en[k] = en;
  endtask

  // Model: consumes the inputs seen at each rising edge and queues the expected outputs.
  initial begin
    ms_a = model_reset();
    ms_b = model_reset();
    forever begin
      @(posedge clock);
      if (clear) begin
        ms_a = model_reset();
        ms_b = model_reset();
      end else begin
        ms_a = model_next(ms_a, 1, req_valid, int'(req_code));
        ms_b = model_next(ms_b, 3, req_valid, int'(req_code));
      end
      q_a.push_back(mk_exp(ms_a));
      q_b.push_back(mk_exp(ms_b));
    end
  end

  // Monitor: compares DUT outputs on the falling edge against the queued expectations.
  initial begin
    prev_en[0] = 32'd0;
    prev_en[1] = 32'd0;
    forever begin
      @(negedge clock);
      if (q_a.size() == 0 || q_b.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        check_dut(0, q_a.pop_front(), en_a, code_a, busy_a, ready_a, err_a);
        check_dut(1, q_b.pop_front(), en_b, code_b, busy_b, ready_b, err_b);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock); #2;
      req_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic [4:0] c);
    @(negedge clock); #2;
    req_valid = 1'b1;
    req_code  = c;
    @(negedge clock); #2;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] rc;
    idle(3);
    clear = 1'b0;
    idle(2);

    issue(5'd20);
    chk("pc_drv_en", en_a, 32'h0010_0000);
    chk("pc_drv_code", {27'd0, code_a}, 32'd20);
    idle(2);
    issue(5'd21);
    chk("mdr_gap_busy", {31'd0, busy_a}, 32'd1);
    idle(5);

    issue(5'd5);
    idle(4);
    issue(5'd5);
    chk("same_code_held", en_a, 32'h0000_0020);
    chk("same_code_ready", {31'd0, ready_a}, 32'd1);
    idle(2);

    issue(5'd3);
    idle(4);
    issue(5'd27);
    chk("illegal_err", {31'd0, err_a}, 32'd1);
    chk("illegal_code", {27'd0, code_a}, 32'd31);
    idle(1);
    issue(5'd31);
    chk("release_no_err", {31'd0, err_a}, 32'd0);
    idle(2);

    issue(5'd0);
    idle(4);
    issue(5'd16);
    clear = 1'b1;
    #1;
    chk("clear_gap_busy", {31'd0, busy_b}, 32'd0);
    chk("clear_gap_ready", {31'd0, ready_b}, 32'd1);
    @(negedge clock); #2;
    clear = 1'b0;
    idle(6);

    issue(5'd7);
    clear = 1'b1;
    #1;
    chk("clear_drive_en", en_a, 32'd0);
    chk("clear_drive_code", {27'd0, code_a}, 32'd31);
    @(negedge clock); #2;
    clear = 1'b0;
    idle(2);

    for (int i = 0; i < 600; i++) begin
      @(negedge clock); #2;
      req_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       rc = 5'd31;
        1:       rc = 5'($urandom_range(24, 30));
        default: rc = 5'($urandom_range(0, 5));
      endcase
      req_code = rc;
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
